rv_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the RV32I core. It replaces the bare programcounter/instruction_memory pairing with a sequential PC generator, a synchronous instruction-memory request port, and a prefetch FIFO. It presents instructions to decode through a valid/ready handshake and supports flush-and-redirect from branch/jump resolution. It sits between the instruction memory and the control_unit/reg_file/imm_gen decode logic.

---
 rtl/rv_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_rv_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_unit.sv
// ----------------------------------------------------------------------------
// rv_fetch_unit
//   Instruction-fetch stage for the RV32I core: a sequential PC generator, a
//   single-outstanding synchronous instruction-memory request port and a small
//   prefetch FIFO that feeds decode through a valid/ready handshake. A redirect
//   from branch/jump resolution flushes the FIFO and restarts fetch.
//
// Ports
//   clk, rst        core clock, asynchronous active-high reset
//   imem_req        instruction memory read request this cycle
//   imem_addr       word-aligned fetch address
//   imem_rdata      read data, valid one cycle after an imem_req cycle
//   if_valid        FIFO head holds a valid instruction
//   if_ready        decode accepts the head this cycle
//   if_instr        head instruction
//   if_pc           PC of the head instruction
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch PC, low two bits ignored
//   fifo_count      current FIFO occupancy
// ----------------------------------------------------------------------------
module rv_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter int unsigned     ILEN       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imem_req,
    output logic [XLEN-1:0]               imem_addr,
    input  logic [ILEN-1:0]               imem_rdata,
    output logic                          if_valid,
    input  logic                          if_ready,
    output logic [ILEN-1:0]               if_instr,
    output logic [XLEN-1:0]               if_pc,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_START   = RESET_PC & ALIGN_MASK;

    // Fetch-side state
    logic [XLEN-1:0]  fetch_pc;
    logic             inflight;
    logic             epoch;
    logic             tag_epoch;
    logic [XLEN-1:0]  tag_pc;

    // Prefetch FIFO storage and pointers
    logic [ILEN-1:0]  fifo_instr [FIFO_DEPTH];
    logic [XLEN-1:0]  fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic [CNT_W-1:0] occupancy;
    logic             issue;
    logic             resp_wr;
    logic             pop;
    logic [XLEN-1:0]  redirect_aligned;

    // Issue / write / pop decisions; a redirect suppresses all of them
    always_comb begin
        occupancy        = CNT_W'(count + CNT_W'(inflight));
        issue            = !rst && !redirect_valid && (occupancy < CNT_W'(FIFO_DEPTH));
        resp_wr          = inflight && (tag_epoch == epoch) && !redirect_valid;
        if_valid         = (count != '0) && !redirect_valid;
        pop              = if_valid && if_ready;
        redirect_aligned = redirect_pc & ALIGN_MASK;
    end

    // Request port and head presentation
    always_comb begin
        imem_req   = issue;
        imem_addr  = fetch_pc;
        fifo_count = count;
        if_instr   = '0;
        if_pc      = '0;
        if (count != '0) begin
            if_instr = fifo_instr[rd_ptr];
            if_pc    = fifo_pc[rd_ptr];
        end
    end

    // PC generator and response tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= PC_START;
            inflight  <= 1'b0;
            epoch     <= 1'b0;
            tag_epoch <= 1'b0;
            tag_pc    <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_aligned;
            inflight <= 1'b0;
            epoch    <= ~epoch;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_pc    <= fetch_pc;
                tag_epoch <= epoch;
                fetch_pc  <= fetch_pc + XLEN'(4);
            end
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (resp_wr) begin
                wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            end
            if (pop) begin
                rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
            end
            case ({resp_wr, pop})
                2'b10:   count <= CNT_W'(count + CNT_W'(1));
                2'b01:   count <= CNT_W'(count - CNT_W'(1));
                default: count <= count;
            endcase
        end
    end

    // FIFO payload storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (resp_wr) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= tag_pc;
        end
    end

endmodule

// File: tb/tb_rv_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_rv_fetch_unit
//   Self-checking bench for rv_fetch_unit. A behavioural model (a queue of
//   {pc, instr} entries plus one pending memory response) predicts every
//   output each cycle. Directed phases walk through the reset, back-pressure,
//   redirect, wrap-around and async-reset scenarios, followed by random
//   ready/redirect/reset traffic.
// ----------------------------------------------------------------------------
module tb_rv_fetch_unit;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ILEN   = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    rv_fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH),
        .ILEN       (ILEN)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_count     (fifo_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Reference model state
    entry_t      mq[$];
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_fpc;

    int n_vec = 0;
    int n_err = 0;
    int valid_seen;

    // Memory contents: word i (address 4*i) holds 0x13 + i*0x100
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 + (a >> 2) * 32'h100;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend    = 1'b0;
        m_pend_pc = '0;
        m_fpc     = RST_PC;
    endtask

    // Compare every output against the model for the current inputs
    task automatic check_outputs();
        bit exp_req;
        bit exp_valid;
        exp_req   = !redirect_valid && ((mq.size() + int'(m_pend)) < int'(DEPTH));
        exp_valid = (mq.size() > 0) && !redirect_valid;
        check_eq("imem_req", 64'(imem_req), 64'(exp_req));
        if (exp_req) check_eq("imem_addr", 64'(imem_addr), 64'(m_fpc));
        check_eq("if_valid", 64'(if_valid), 64'(exp_valid));
        check_eq("fifo_count", 64'(fifo_count), 64'(mq.size()));
        if (mq.size() > 0) begin
            check_eq("if_pc", 64'(if_pc), 64'(mq[0].pc));
            check_eq("if_instr", 64'(if_instr), 64'(mq[0].instr));
        end
    endtask

    // Advance the model across one rising edge
    task automatic model_update(input bit rdy, input bit rv, input logic [31:0] rpc);
        bit issue;
        if (rv) begin
            mq.delete();
            m_pend = 1'b0;
            m_fpc  = rpc & ~32'h3;
        end else begin
            issue = (mq.size() + int'(m_pend)) < int'(DEPTH);
            if (rdy && mq.size() > 0) void'(mq.pop_front());
            if (m_pend) mq.push_back('{pc: m_pend_pc, instr: mem_word(m_pend_pc)});
            m_pend = issue;
            if (issue) begin
                m_pend_pc = m_fpc;
                m_fpc     = m_fpc + 32'd4;
            end
        end
    endtask

    // One clock cycle: drive inputs, check, clock, respond as memory
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
        logic        req_s;
        logic [31:0] addr_s;
        @(negedge clk);
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        check_outputs();
        if (if_valid) valid_seen++;
        req_s  = imem_req;
        addr_s = imem_addr;
        @(posedge clk);
        model_update(rdy, rv, rpc);
        #1;
        imem_rdata = req_s ? mem_word(addr_s) : $urandom();
    endtask

    // Assert reset between clock edges and check that outputs clear at once
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        #1;
        check_eq("rst_imem_req", 64'(imem_req), 64'd0);
        check_eq("rst_if_valid", 64'(if_valid), 64'd0);
        check_eq("rst_fifo_count", 64'(fifo_count), 64'd0);
        check_eq("rst_if_instr", 64'(if_instr), 64'd0);
        check_eq("rst_if_pc", 64'(if_pc), 64'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        imem_rdata = $urandom();
        model_reset();
    endtask

    initial begin
        rst            = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_rdata     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("init_imem_req", 64'(imem_req), 64'd0);
        check_eq("init_if_valid", 64'(if_valid), 64'd0);
        check_eq("init_fifo_count", 64'(fifo_count), 64'd0);
        check_eq("init_if_instr", 64'(if_instr), 64'd0);
        check_eq("init_if_pc", 64'(if_pc), 64'd0);
        rst = 1'b0;

        // Streaming with decode always ready; crosses the 2^32 PC wrap
        valid_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) valid_seen = 0;
            step(1'b1, 1'b0, '0);
        end
        check_eq("throughput", 64'(valid_seen), 64'd16);

        // Back-pressure: FIFO fills to depth, then drains in order
        async_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
        check_eq("full_count", 64'(fifo_count), 64'(DEPTH));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0);

        // Redirect with three queued entries and one response in flight
        async_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_0103);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // Redirect on a cycle where a handshake would otherwise occur
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // Back-to-back redirects, last one wins
        step(1'b1, 1'b1, 32'h0000_0300);
        step(1'b1, 1'b1, 32'h0000_0400);
        step(1'b1, 1'b1, 32'h0000_0506);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // Redirect right before the address wrap
        step(1'b1, 1'b1, 32'hFFFF_FFF4);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0);

        // Async reset in the middle of a stream
        async_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit          rdy;
            bit          rv;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom();
            if ($urandom_range(0, 199) == 0) async_reset();
            step(rdy, rv, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
